alu_cmd_issuer: RTL and testbench

//  Initiator side of the 4-bit ALU interface (s/a/b in, y out). Accepts operation commands on a

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_cmd_fifo.sv | 61 ++++++
 rtl/alu_cmd_issuer.sv | 152 +++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU command issuer: ALU op encodings and issuer FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_CMP = 2'b10,
    OP_AND = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } issuer_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with an occupancy counter; no bypass from push to pop.
module alu_cmd_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; empty/full come from the counter, so stale data is never read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues buffered commands to an ALU, waits its latency, and returns results in order.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [1:0]       alu_s,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_op,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_zero,
  output logic             busy,
  output logic [7:0]       ops_done
);

  localparam int ENTRY_W = 2*WIDTH + 2;
  localparam int CNT_W   = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
  logic [1:0]         head_op;
  logic [WIDTH-1:0]   head_a, head_b;
  logic               load;

  issuer_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  alu_op_e          alu_s_q, alu_s_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_zero_q, rsp_zero_d;
  logic [1:0]       rsp_op_q, rsp_op_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic [7:0]       ops_done_q, ops_done_d;

  assign cmd_ready  = !fifo_full;
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_wdata = {cmd_op, cmd_a, cmd_b};
  assign {head_op, head_a, head_b} = fifo_rdata;

  alu_cmd_fifo #(
    .DW    (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    // NOTE: every signal gets a hold-value default first, so no path through the case infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_s_d     = alu_s_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_op_d    = rsp_op_q;
    rsp_y_d     = rsp_y_q;
    rsp_zero_d  = rsp_zero_q;
    ops_done_d  = ops_done_q;
    fifo_pop    = 1'b0;
    load        = 1'b0;

    case (state_q)
      IDLE: load = !fifo_empty;
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rsp_y_d     = alu_y;
          rsp_op_d    = alu_s_q;
          rsp_zero_d  = (alu_y == '0);
          rsp_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + 8'd1;
          state_d     = IDLE;
          load        = !fifo_empty;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pop from IDLE or straight out of a completed HOLD share one load path.
    if (load) begin
      fifo_pop = 1'b1;
      alu_s_d  = alu_op_e'(head_op);
      alu_a_d  = head_a;
      alu_b_d  = head_b;
      cnt_d    = CNT_W'(ALU_LAT);
      state_d  = WAIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_s_q     <= OP_ADD;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= '0;
      rsp_y_q     <= '0;
      rsp_zero_q  <= 1'b1;
      ops_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_s_q     <= alu_s_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_op_q    <= rsp_op_d;
      rsp_y_q     <= rsp_y_d;
      rsp_zero_q  <= rsp_zero_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign alu_s     = alu_s_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_op    = rsp_op_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_zero  = rsp_zero_q;
  assign ops_done  = ops_done_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: a combinational-ALU instance and a 2-cycle-latency ALU instance,
// each with an in-order scoreboard built from plain arithmetic on accepted commands.
module tb_alu_cmd_issuer;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] y;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: combinational ALU
  logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_zero, busy;
  logic [1:0] cmd_op, alu_s, rsp_op;
  logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_y, rsp_y;
  logic [7:0] ops_done;

  // Instance 1: ALU with two clock edges of latency
  logic       cmd_valid_2, cmd_ready_2, rsp_valid_2, rsp_ready_2, rsp_zero_2, busy_2;
  logic [1:0] cmd_op_2, alu_s_2, rsp_op_2;
  logic [3:0] cmd_a_2, cmd_b_2, alu_a_2, alu_b_2, alu_y_2, rsp_y_2, y_p1, y_p2;
  logic [7:0] ops_done_2;

  int   total = 0;
  int   bad   = 0;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int   n_rsp0 = 0, n_cmd0 = 0, n_rsp1 = 0;
  logic [7:0] done0 = 8'd0, done1 = 8'd0;

  alu_cmd_issuer #(.WIDTH(4), .FIFO_DEPTH(4), .ALU_LAT(0)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_y(rsp_y),
    .rsp_zero(rsp_zero), .busy(busy), .ops_done(ops_done)
  );

  alu_cmd_issuer #(.WIDTH(4), .FIFO_DEPTH(4), .ALU_LAT(2)) dut_lat2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_2), .cmd_ready(cmd_ready_2),
    .cmd_op(cmd_op_2), .cmd_a(cmd_a_2), .cmd_b(cmd_b_2),
    .alu_s(alu_s_2), .alu_a(alu_a_2), .alu_b(alu_b_2), .alu_y(alu_y_2),
    .rsp_valid(rsp_valid_2), .rsp_ready(rsp_ready_2), .rsp_op(rsp_op_2), .rsp_y(rsp_y_2),
    .rsp_zero(rsp_zero_2), .busy(busy_2), .ops_done(ops_done_2)
  );

  // ALU stand-in: compare drives zero on y.
  function automatic logic [3:0] alu_model(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return 4'h0;
      default: return a & b;
    endcase
  endfunction

  assign alu_y = alu_model(alu_s, alu_a, alu_b);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      y_p1 <= 4'h0;
      y_p2 <= 4'h0;
    end else begin
      y_p1 <= alu_model(alu_s_2, alu_a_2, alu_b_2);
      y_p2 <= y_p1;
    end
  end
  assign alu_y_2 = y_p2;

  // Expected result from integer arithmetic modulo 16.
  function automatic logic [3:0] ref_y(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      2'd0:    r = (ia + ib) % 16;
      2'd1:    r = (ia - ib + 16) % 16;
      2'd2:    r = 0;
      default: r = ia & ib;
    endcase
    return r[3:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: sampled at negedge, i.e. the state that the next rising edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      done0 = 8'd0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (q0.size() == 0) check("rsp0_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          e0 = q0.pop_front();
          check("rsp0_y", 32'(rsp_y), 32'(e0.y));
          check("rsp0_op", 32'(rsp_op), 32'(e0.op));
          check("rsp0_zero", 32'(rsp_zero), 32'(e0.y == 4'h0));
          done0++;
          n_rsp0++;
        end
      end
      if (cmd_valid && cmd_ready) begin
        e0.op = cmd_op;
        e0.y  = ref_y(cmd_op, cmd_a, cmd_b);
        q0.push_back(e0);
        n_cmd0++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
      done1 = 8'd0;
    end else begin
      if (rsp_valid_2 && rsp_ready_2) begin
        if (q1.size() == 0) check("rsp1_unexpected", 32'(rsp_valid_2), 32'd0);
        else begin
          e1 = q1.pop_front();
          check("rsp1_y", 32'(rsp_y_2), 32'(e1.y));
          check("rsp1_op", 32'(rsp_op_2), 32'(e1.op));
          check("rsp1_zero", 32'(rsp_zero_2), 32'(e1.y == 4'h0));
          done1++;
          n_rsp1++;
        end
      end
      if (cmd_valid_2 && cmd_ready_2) begin
        e1.op = cmd_op_2;
        e1.y  = ref_y(cmd_op_2, cmd_a_2, cmd_b_2);
        q1.push_back(e1);
      end
    end
  end

  task automatic run_one(input string tag, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] exp_y, input logic exp_zero);
    int n;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1; rsp_ready = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    check({tag, "_timeout"}, 32'(n < 20), 32'd1);
    check({tag, "_y"}, 32'(rsp_y), 32'(exp_y));
    check({tag, "_zero"}, 32'(rsp_zero), 32'(exp_zero));
    tick();
    check({tag, "_released"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic drain0(input string tag);
    int n;
    n = 0;
    while ((busy || rsp_valid) && n < 100) begin tick(); n++; end
    check(tag, 32'(n < 100), 32'd1);
  endtask

  initial begin
    int k, n, stable, rdy, base;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_a = 4'd0; cmd_b = 4'd0; rsp_ready = 1'b0;
    cmd_valid_2 = 1'b0; cmd_op_2 = 2'd0; cmd_a_2 = 4'd0; cmd_b_2 = 4'd0; rsp_ready_2 = 1'b0;
    tick(); tick();

    // Reset values
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_s", 32'(alu_s), 32'd0);
    check("rst_rsp_zero", 32'(rsp_zero), 32'd1);
    check("rst_rsp_y", 32'(rsp_y), 32'd0);
    check("rst_ops_done", 32'(ops_done), 32'd0);
    rst = 1'b0;
    tick();

    // Single add: accepted at E0, ALU driven after E1, response after E2
    cmd_op = 2'd0; cmd_a = 4'd3; cmd_b = 4'd5; cmd_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("add_e0_valid", 32'(rsp_valid), 32'd0);
    tick();
    check("add_e1_alu_a", 32'(alu_a), 32'd3);
    check("add_e1_alu_b", 32'(alu_b), 32'd5);
    check("add_e1_alu_s", 32'(alu_s), 32'd0);
    check("add_e1_valid", 32'(rsp_valid), 32'd0);
    tick();
    check("add_e2_valid", 32'(rsp_valid), 32'd1);
    check("add_e2_y", 32'(rsp_y), 32'd8);
    check("add_e2_op", 32'(rsp_op), 32'd0);
    check("add_e2_zero", 32'(rsp_zero), 32'd0);
    tick();
    check("add_ops_done", 32'(ops_done), 32'd1);

    // Wrap and zero cases
    run_one("sub_wrap", 2'd1, 4'd2, 4'd5, 4'hD, 1'b0);
    run_one("and_zero", 2'd3, 4'd3, 4'd4, 4'h0, 1'b1);
    run_one("add_wrap", 2'd0, 4'hF, 4'd1, 4'h0, 1'b1);
    run_one("cmp", 2'd2, 4'd7, 4'd7, 4'h0, 1'b1);

    // Full FIFO under backpressure: five accepted, then cmd_ready drops
    rsp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      cmd_valid = (k < 6);
      cmd_op = 2'(k % 4); cmd_a = 4'(k + 1); cmd_b = 4'(k + 2);
      rdy = int'(cmd_ready);
      tick();
      if (rdy != 0 && k < 6) k++;
    end
    check("full_accepted", 32'(k), 32'd5);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);

    // Held response stays stable while rsp_ready is low
    base = int'(done0);
    stable = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid && rsp_y == 4'd3 && rsp_op == 2'd0 && alu_s == 2'd0 && alu_a == 4'd1 && alu_b == 4'd2)
        stable++;
    end
    check("bp_stable", 32'(stable), 32'd10);
    check("bp_ops_done", 32'(ops_done), 32'(base));

    base = n_rsp0;
    rsp_ready = 1'b1;
    n = 0;
    while (k < 6 && n < 40) begin
      cmd_valid = 1'b1;
      cmd_op = 2'(k % 4); cmd_a = 4'(k + 1); cmd_b = 4'(k + 2);
      rdy = int'(cmd_ready);
      tick();
      if (rdy != 0) k++;
      n++;
    end
    cmd_valid = 1'b0;
    check("full_sixth_accepted", 32'(k), 32'd6);
    drain0("full_drain");
    check("full_rsp_count", 32'(n_rsp0 - base), 32'd6);
    check("full_ops_done", 32'(ops_done), 32'(done0));

    // Random traffic with random backpressure
    base = n_rsp0;
    k = n_cmd0;
    for (int c = 0; c < 400; c++) begin
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_op = 2'($urandom_range(0, 3));
      cmd_a = 4'($urandom_range(0, 15));
      cmd_b = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain0("rand_drain");
    check("rand_rsp_count", 32'(n_rsp0 - base), 32'(n_cmd0 - k));
    check("rand_ops_done", 32'(ops_done), 32'(done0));

    // Two-cycle ALU: command at E0 gives rsp_valid after E4
    cmd_op_2 = 2'd1; cmd_a_2 = 4'd9; cmd_b_2 = 4'd4; cmd_valid_2 = 1'b1; rsp_ready_2 = 1'b0;
    tick();
    cmd_valid_2 = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("lat2_e%0d_valid", e), 32'(rsp_valid_2), 32'(e == 4));
    end
    check("lat2_y", 32'(rsp_y_2), 32'd5);
    check("lat2_op", 32'(rsp_op_2), 32'd1);
    rsp_ready_2 = 1'b1;
    tick();
    check("lat2_ops_done", 32'(ops_done_2), 32'd1);

    // Reset while in WAIT with three commands queued behind it
    rsp_ready_2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid_2 = 1'b1;
      cmd_op_2 = 2'(i); cmd_a_2 = 4'(i + 5); cmd_b_2 = 4'(i + 1);
      tick();
    end
    cmd_valid_2 = 1'b0;
    check("prerst_valid", 32'(rsp_valid_2), 32'd0);
    check("prerst_busy", 32'(busy_2), 32'd1);
    rst = 1'b1;
    tick();
    check("rst2_rsp_valid", 32'(rsp_valid_2), 32'd0);
    check("rst2_busy", 32'(busy_2), 32'd0);
    check("rst2_cmd_ready", 32'(cmd_ready_2), 32'd1);
    check("rst2_alu_s", 32'(alu_s_2), 32'd0);
    check("rst2_ops_done", 32'(ops_done_2), 32'd0);
    rst = 1'b0;
    rsp_ready_2 = 1'b1;
    base = n_rsp1;
    for (int c = 0; c < 10; c++) tick();
    check("rst2_no_rsp", 32'(n_rsp1 - base), 32'd0);
    check("rst2_idle", 32'(busy_2), 32'd0);

    // 256 commands wrap ops_done back to zero
    base = n_rsp1;
    k = 0;
    n = 0;
    while (k < 256 && n < 3000) begin
      cmd_valid_2 = 1'b1;
      cmd_op_2 = 2'($urandom_range(0, 3));
      cmd_a_2 = 4'($urandom_range(0, 15));
      cmd_b_2 = 4'($urandom_range(0, 15));
      rdy = int'(cmd_ready_2);
      tick();
      if (rdy != 0) k++;
      n++;
    end
    cmd_valid_2 = 1'b0;
    n = 0;
    while ((busy_2 || rsp_valid_2) && n < 100) begin tick(); n++; end
    check("wrap_drain", 32'(n < 100), 32'd1);
    check("wrap_rsp_count", 32'(n_rsp1 - base), 32'd256);
    check("wrap_ops_done", 32'(ops_done_2), 32'd0);
    check("wrap_model", 32'(ops_done_2), 32'(done1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
